unstripe_ctrl: RTL and testbench
================================

Name: unstripe_ctrl

Overview:
- Sequences the 2-lane un-striping datapath on clk_2f.
- Buffers each lane in a small deskew FIFO and waits until both lanes hold data.
- Then merges words in strict lane_0, lane_1, lane_0, ... order onto one output stream with a valid/ready handshake.
- Detects and counts lane underruns and overflows; sits between the per-lane receive logic and the byte un-striper consumer.

Parameters:
- DATA_W, 32, lane and output word width.
- FIFO_DEPTH, 4, per-lane FIFO depth in words; power of 2, minimum 2.
- ALIGN_MIN, 1, words each FIFO must hold before IDLE->RUN; range 1..FIFO_DEPTH.

Ports:
- clk_2f  in  1  clock, 2x lane word rate
- reset  in  1  synchronous, active-high
- lane_0  in  DATA_W  lane 0 word
- valid_0  in  1  lane_0 word present this cycle
- lane_1  in  DATA_W  lane 1 word
- valid_1  in  1  lane_1 word present this cycle
- out_ready  in  1  consumer accepts data_out this cycle
- data_out  out  DATA_W  merged word
- valid_out  out  1  data_out holds a word
- selector  out  1  lane to be popped next (0/1)
- active  out  1  FSM in RUN or STALL
- overflow_err  out  1  sticky; a lane word was dropped
- underrun_cnt  out  8  saturating count of STALL cycles

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk_2f. All state is updated on the rising edge of clk_2f.
- Reset, in any state including mid-stream:
  - Both FIFOs are emptied.
  - state=IDLE.
  - data_out=0, valid_out=0, selector=0, active=0, overflow_err=0, underrun_cnt=0.
  - Outputs are never driven to Z.
- FIFO write:
  - valid_x=1 with FIFO x not full writes lane_x.
  - If FIFO x is full and no pop of x happens that cycle, the word is dropped and overflow_err is set to 1 until reset.
  - A write and a pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
  - A write into a full FIFO with a simultaneous pop is accepted.
- Load opportunity: load = ~valid_out | out_ready.
  - While valid_out=1 and out_ready=0, data_out and valid_out hold stable.
  - If out_ready=1 and no pop occurs, valid_out drops to 0.
- FSM uses registered FIFO counts.
  - IDLE:
    - selector=0, active=0.
    - Go to RUN when count0>=ALIGN_MIN and count1>=ALIGN_MIN.
  - RUN, on a load opportunity:
    - If FIFO[selector] is non-empty: pop it into data_out, set valid_out=1, toggle selector.
    - If FIFO[selector] is empty and both FIFOs are empty and selector=0: go to IDLE; this is the stream end on a pair boundary.
    - Otherwise go to STALL; selector is unchanged.
  - STALL:
    - Each cycle, underrun_cnt increments, saturating at 255.
    - When FIFO[selector] becomes non-empty, go to RUN. The pop happens on the next load opportunity in RUN.
    - Lane order is never skipped or reordered.
  - With no load opportunity, RUN stays in RUN and nothing is popped.
- Latency: first words written on both lanes at edge E0 -> RUN at E1 -> lane_0 word on data_out with valid_out=1 after E2.
- Throughput: one word per cycle while both FIFOs are non-empty and out_ready=1.
- Simultaneous valid_0 and valid_1 are normal. Writes during IDLE/STALL are buffered. Writes while the FIFO is full are handled as above.

Test Plan:
- Reset, then valid_0=valid_1=1 with 0xA0/0xB0, 0xA1/0xB1 on alternate cycles, out_ready=1 -> data_out sequence A0,B0,A1,B1; first valid_out 2 cycles after the first write; selector toggles 0,1,0,1.
- Lane skew: lane_1 words arrive 3 cycles after lane_0 (ALIGN_MIN=1) -> no output until lane_1 data arrives; then A0,B0 in order; underrun_cnt=0.
- Backpressure: out_ready=0 for 5 cycles while valid_out=1 with data_out=0x11111111 -> data_out is held constant; no FIFO pops; on release the stream resumes in order with no loss.
- Overflow: valid_0 held high for 6 cycles, lane_1 idle, FIFO_DEPTH=4 -> first 4 words kept, overflow_err=1; later RUN outputs A0 first after lane_1 fills.
- Underrun: lane_1 stops after B1 while lane_0 supplies A2 -> A2 output, then STALL; underrun_cnt counts stall cycles and saturates at 255 after 300 cycles; B2 then resumes the stream.
- Reset mid-stream with valid_out=1 -> after the edge, all outputs are 0 and state is IDLE; the next aligned stream starts again from lane_0.

Source files
------------

// File: rtl/unstripe_ctrl_if.sv
// Handshake and lane bundle between the per-lane receivers, the un-stripe
// controller and the downstream byte un-striper.
interface unstripe_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] lane_0;
    logic              valid_0;
    logic [DATA_W-1:0] lane_1;
    logic              valid_1;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              selector;
    logic              active;
    logic              overflow_err;
    logic [7:0]        underrun_cnt;

    modport master (
        output lane_0, valid_0, lane_1, valid_1, out_ready,
        input  data_out, valid_out, selector, active, overflow_err, underrun_cnt
    );

    modport slave (
        input  lane_0, valid_0, lane_1, valid_1, out_ready,
        output data_out, valid_out, selector, active, overflow_err, underrun_cnt
    );
endinterface

// File: rtl/unstripe_ctrl.sv
// Two-lane un-stripe sequencer: per-lane deskew FIFOs, alignment wait, and a
// strict lane_0/lane_1 alternating merge onto one valid/ready output stream.
module unstripe_ctrl #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ALIGN_MIN  = 1
) (
    input  logic            clk_2f,
    input  logic            reset,
    unstripe_ctrl_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        sat_inc8 = (val == 8'hFF) ? 8'hFF : (val + 8'd1);
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic              sel_r;
    logic              next_sel_s;
    logic [DATA_W-1:0] data_out_r;
    logic              valid_out_r;
    logic              active_r;
    logic              overflow_err_r;
    logic [7:0]        underrun_cnt_r;

    logic [DATA_W-1:0] mem_r     [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r  [2];
    logic [PTR_W-1:0]  wr_ptr_r  [2];
    logic [CNT_W-1:0]  count_r   [2];
    logic [DATA_W-1:0] lane_in_s [2];
    logic [1:0]        valid_in_s;
    logic [1:0]        full_s;
    logic [1:0]        wr_s;
    logic [1:0]        pop_s;
    logic [1:0]        drop_s;
    logic              load_s;
    logic [DATA_W-1:0] head_s;

    assign lane_in_s[0] = bus.lane_0;
    assign lane_in_s[1] = bus.lane_1;
    assign valid_in_s   = {bus.valid_1, bus.valid_0};

    // A new word may be presented whenever the output register is empty or being taken.
    assign load_s = ~valid_out_r | bus.out_ready;
    assign head_s = mem_r[sel_r][rd_ptr_r[sel_r]];

    // Per-lane write acceptance; a full FIFO still accepts when it is popped in the same cycle.
    always_comb begin
        full_s = 2'b00;
        wr_s   = 2'b00;
        drop_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            full_s[i] = (count_r[i] == CNT_W'(FIFO_DEPTH));
            wr_s[i]   = valid_in_s[i] & (~full_s[i] | pop_s[i]);
            drop_s[i] = valid_in_s[i] & full_s[i] & ~pop_s[i];
        end
    end

    // Next-state, lane selection and pop decisions, all from registered FIFO counts.
    always_comb begin
        next_state_s = state_r;
        next_sel_s   = sel_r;
        pop_s        = 2'b00;
        case (state_r)
            ST_IDLE: begin
                next_sel_s = 1'b0;
                if ((count_r[0] >= CNT_W'(ALIGN_MIN)) && (count_r[1] >= CNT_W'(ALIGN_MIN))) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (load_s) begin
                    if (count_r[sel_r] != '0) begin
                        pop_s[sel_r] = 1'b1;
                        next_sel_s   = ~sel_r;
                    end else if ((count_r[0] == '0) && (count_r[1] == '0) && (sel_r == 1'b0)) begin
                        // Stream ended cleanly on a lane pair boundary.
                        next_state_s = ST_IDLE;
                    end else begin
                        next_state_s = ST_STALL;
                    end
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STALL: begin
                if (count_r[sel_r] != '0) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_STALL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_sel_s   = 1'b0;
            end
        endcase
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rd_ptr_r[i] <= '0;
                wr_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_W'(1);
                end
                if (wr_s[i] && !pop_s[i]) begin
                    count_r[i] <= count_r[i] + CNT_W'(1);
                end else if (!wr_s[i] && pop_s[i]) begin
                    count_r[i] <= count_r[i] - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk_2f) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_s[i]) begin
                mem_r[i][wr_ptr_r[i]] <= lane_in_s[i];
            end
        end
    end

    // FSM state, output word register and error/status tracking.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            sel_r          <= 1'b0;
            data_out_r     <= '0;
            valid_out_r    <= 1'b0;
            active_r       <= 1'b0;
            overflow_err_r <= 1'b0;
            underrun_cnt_r <= 8'd0;
        end else begin
            state_r  <= next_state_s;
            sel_r    <= next_sel_s;
            active_r <= (next_state_s != ST_IDLE);
            if (|pop_s) begin
                data_out_r  <= head_s;
                valid_out_r <= 1'b1;
            end else if (load_s) begin
                valid_out_r <= 1'b0;
            end
            if (|drop_s) begin
                overflow_err_r <= 1'b1;
            end
            if (state_r == ST_STALL) begin
                underrun_cnt_r <= sat_inc8(underrun_cnt_r);
            end
        end
    end

    assign bus.data_out     = data_out_r;
    assign bus.valid_out    = valid_out_r;
    assign bus.selector     = sel_r;
    assign bus.active       = active_r;
    assign bus.overflow_err = overflow_err_r;
    assign bus.underrun_cnt = underrun_cnt_r;

endmodule

// File: tb/tb_unstripe_ctrl.sv
// Directed bench for unstripe_ctrl: alignment, skew, backpressure, overflow,
// underrun saturation and mid-stream reset.
module tb_unstripe_ctrl;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    unstripe_ctrl_if #(.DATA_W(32)) bus ();

    unstripe_ctrl #(.DATA_W(32), .FIFO_DEPTH(4), .ALIGN_MIN(1)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0,
                         input logic v1, input logic [31:0] d1, input logic rdy);
        bus.valid_0   = v0;
        bus.lane_0    = d0;
        bus.valid_1   = v1;
        bus.lane_1    = d1;
        bus.out_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic s);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'd1);
        chk({tag, ".data"}, bus.data_out, d);
        chk({tag, ".sel"}, 32'(bus.selector), 32'(s));
    endtask

    task automatic chk_empty(input string tag, input logic act);
        chk({tag, ".valid"}, 32'(bus.valid_out), 32'd0);
        chk({tag, ".active"}, 32'(bus.active), 32'(act));
    endtask

    task automatic do_reset();
        idle(1'b1);
        reset = 1'b1;
        tick();
        tick();
        chk("rst.data", bus.data_out, 32'h0);
        chk("rst.valid", 32'(bus.valid_out), 32'd0);
        chk("rst.sel", 32'(bus.selector), 32'd0);
        chk("rst.active", 32'(bus.active), 32'd0);
        chk("rst.ovf", 32'(bus.overflow_err), 32'd0);
        chk("rst.ucnt", 32'(bus.underrun_cnt), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        idle(1'b1);

        // Aligned stream, words on alternate cycles.
        do_reset();
        drive(1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1);
        tick();
        chk_empty("al.e0", 1'b0);
        idle(1'b1);
        tick();
        chk_empty("al.e1", 1'b1);
        drive(1'b1, 32'hA1, 1'b1, 32'hB1, 1'b1);
        tick();
        chk_word("al.w0", 32'hA0, 1'b1);
        idle(1'b1);
        tick();
        chk_word("al.w1", 32'hB0, 1'b0);
        tick();
        chk_word("al.w2", 32'hA1, 1'b1);
        tick();
        chk_word("al.w3", 32'hB1, 1'b0);
        tick();
        chk_empty("al.end", 1'b0);

        // Lane 1 arrives three cycles after lane 0.
        do_reset();
        drive(1'b1, 32'hA0, 1'b0, 32'h0, 1'b1);
        tick();
        idle(1'b1);
        tick();
        tick();
        chk_empty("sk.wait", 1'b0);
        drive(1'b0, 32'h0, 1'b1, 32'hB0, 1'b1);
        tick();
        chk_empty("sk.b0", 1'b0);
        idle(1'b1);
        tick();
        chk_empty("sk.run", 1'b1);
        tick();
        chk_word("sk.w0", 32'hA0, 1'b1);
        tick();
        chk_word("sk.w1", 32'hB0, 1'b0);
        tick();
        chk_empty("sk.end", 1'b0);
        chk("sk.ucnt", 32'(bus.underrun_cnt), 32'd0);

        // Backpressure holds the output word.
        do_reset();
        drive(1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b0);
        tick();
        drive(1'b1, 32'h33333333, 1'b1, 32'h44444444, 1'b0);
        tick();
        idle(1'b0);
        tick();
        chk_word("bp.first", 32'h11111111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_word("bp.hold", 32'h11111111, 1'b1);
        end
        idle(1'b1);
        tick();
        chk_word("bp.w1", 32'h22222222, 1'b0);
        tick();
        chk_word("bp.w2", 32'h33333333, 1'b1);
        tick();
        chk_word("bp.w3", 32'h44444444, 1'b0);
        tick();
        chk_empty("bp.end", 1'b0);

        // Overflow: six lane-0 words into a depth-4 FIFO, lane 1 idle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0, 32'h0, 1'b1);
            tick();
            if (i == 3) begin
                chk("ov.full", 32'(bus.overflow_err), 32'd0);
            end
        end
        chk("ov.err", 32'(bus.overflow_err), 32'd1);
        chk_empty("ov.idle", 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'hB0 + 32'(i), 1'b1);
            tick();
        end
        idle(1'b1);
        // Four lane-1 writes span the RUN entry and first pop; output started two edges ago.
        chk_word("ov.w1", 32'hB0, 1'b0);
        for (int i = 2; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk_word("ov.wa", 32'hA0 + 32'(i / 2), 1'b1);
            end else begin
                chk_word("ov.wb", 32'hB0 + 32'(i / 2), 1'b0);
            end
        end
        tick();
        chk_empty("ov.end", 1'b0);
        chk("ov.sticky", 32'(bus.overflow_err), 32'd1);

        // Underrun: lane 1 stops after B1, lane 0 supplies A2.
        do_reset();
        drive(1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1);
        tick();
        drive(1'b1, 32'hA1, 1'b1, 32'hB1, 1'b1);
        tick();
        drive(1'b1, 32'hA2, 1'b0, 32'h0, 1'b1);
        tick();
        chk_word("ur.w0", 32'hA0, 1'b1);
        idle(1'b1);
        tick();
        chk_word("ur.w1", 32'hB0, 1'b0);
        tick();
        chk_word("ur.w2", 32'hA1, 1'b1);
        tick();
        chk_word("ur.w3", 32'hB1, 1'b0);
        tick();
        chk_word("ur.w4", 32'hA2, 1'b1);
        tick();
        chk_empty("ur.stall", 1'b1);
        chk("ur.ucnt0", 32'(bus.underrun_cnt), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("ur.ucnt10", 32'(bus.underrun_cnt), 32'd10);
        for (int i = 0; i < 290; i++) begin
            tick();
        end
        chk("ur.sat", 32'(bus.underrun_cnt), 32'd255);
        chk("ur.sel", 32'(bus.selector), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 32'hB2, 1'b1);
        tick();
        idle(1'b1);
        tick();
        chk_empty("ur.resume", 1'b1);
        tick();
        chk_word("ur.w5", 32'hB2, 1'b0);
        chk("ur.sat2", 32'(bus.underrun_cnt), 32'd255);
        tick();
        chk_empty("ur.end", 1'b0);

        // Reset while a word is on the output and words remain buffered.
        do_reset();
        drive(1'b1, 32'hA0, 1'b1, 32'hB0, 1'b1);
        tick();
        drive(1'b1, 32'hA1, 1'b1, 32'hB1, 1'b1);
        tick();
        idle(1'b1);
        tick();
        chk_word("mr.w0", 32'hA0, 1'b1);
        reset = 1'b1;
        tick();
        chk("mr.data", bus.data_out, 32'h0);
        chk("mr.valid", 32'(bus.valid_out), 32'd0);
        chk("mr.sel", 32'(bus.selector), 32'd0);
        chk("mr.active", 32'(bus.active), 32'd0);
        reset = 1'b0;
        drive(1'b1, 32'hC0, 1'b1, 32'hD0, 1'b1);
        tick();
        idle(1'b1);
        tick();
        chk_empty("mr.run", 1'b1);
        tick();
        chk_word("mr.c0", 32'hC0, 1'b1);
        tick();
        chk_word("mr.d0", 32'hD0, 1'b0);
        tick();
        chk_empty("mr.end", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
